seq_mul_div: RTL and testbench



---
 rtl/mul_div_pkg.sv | 13 +
 rtl/seq_mul_div_div_step.sv | 27 ++
 rtl/seq_mul_div.sv | 115 +++++++++++
 tb/tb_seq_mul_div.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared types for the sequential multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/seq_mul_div_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor on entry, so a restored value always fits back into WIDTH bits.
    always_comb begin
        shifted = {rem, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WIDTH];
        if (q_bit) begin
            rem_next = diff[WIDTH-1:0];
        end else begin
            rem_next = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_mul_div.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring), one bit per clock.
module seq_mul_div
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero,
    output state_t             state_dbg
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is high only in IDLE; out_valid is high only in DONE and, once raised,
    // result/div_by_zero stay unchanged until the edge where out_ready is seen high.

    state_t             state;
    logic               op_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;

    // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (acc[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_next  = {rem_next, acc[WIDTH-2:0], q_bit};
        step_next = (op_r == OP_DIV) ? div_next : mul_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            op_r        <= OP_MUL;
            opnd        <= '0;
            acc         <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        opnd     <= (op == OP_DIV) ? b : a;
                        acc      <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? a : b)};
                        count    <= CW'(WIDTH - 1);
                        in_ready <= 1'b0;
                        if (op == OP_DIV && b == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            result      <= {a, {WIDTH{1'b1}}};
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= step_next;
                    if (count == '0) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        result      <= step_next;
                        div_by_zero <= 1'b0;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_seq_mul_div.sv
// Bench for seq_mul_div: timeline/arithmetic model checked every cycle plus literal directed cases.
module tb_seq_mul_div;
    import mul_div_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           op = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic           div_by_zero;
    state_t         state_dbg;

    int checks = 0;
    int failures = 0;

    seq_mul_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {div_by_zero, result} from plain arithmetic.
    function automatic logic [2*W:0] ref_calc(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] r;
        logic           z;
        z = 1'b0;
        if (o == OP_MUL) begin
            r = (2*W)'(x) * (2*W)'(y);
        end else if (y == '0) begin
            r = {x, {W{1'b1}}};
            z = 1'b1;
        end else begin
            r = {W'(x % y), W'(x / y)};
        end
        return {z, r};
    endfunction

    // ---------------- behavioural model ----------------
    logic [2*W:0] exp_q[$];
    logic         m_ready = 1'b1;
    logic         m_valid = 1'b0;
    int           m_wait = 0;
    logic         started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_wait  = 0;
            exp_q.delete();
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
                void'(exp_q.pop_front());
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (m_ready && in_valid) begin
            exp_q.push_back(ref_calc(op, a, b));
            m_ready = 1'b0;
            if (op == OP_DIV && b == '0) m_valid = 1'b1;
            else m_wait = W;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("in_ready", in_ready, m_ready);
            check("out_valid", out_valid, m_valid);
            if (m_valid && exp_q.size() > 0) begin
                check("result", result, exp_q[0][2*W-1:0]);
                check("div_by_zero", div_by_zero, exp_q[0][2*W]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready(output logic ok);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    // Latency is counted in rising edges after the accepting edge until out_valid is seen.
    task automatic do_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic chk, input logic [2*W-1:0] lit_res, input logic lit_dbz,
                         input int hold);
        int   lat;
        int   exp_lat;
        logic ok;
        @(negedge clk);
        wait_ready(ok);
        if (!ok) return;
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = (hold == 0);
        exp_lat   = (o == OP_DIV && y == '0) ? 0 : W;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 3*W) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check("result_timeout", 0, 1);
            return;
        end
        check("latency", lat, exp_lat);
        if (chk) begin
            check("lit_result", result, lit_res);
            check("lit_dbz", div_by_zero, lit_dbz);
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("held_result", result, lit_res);
            check("held_in_ready", in_ready, 0);
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("handoff_valid_low", out_valid, 0);
        check("handoff_ready_high", in_ready, 1);
        out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2*W:0] e;
        logic         ok;
        logic         ro;
        logic [W-1:0] rx, ry;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_state", state_dbg, IDLE);
        rst_n = 1'b1;

        do_op(OP_MUL, 8'd24,  8'd2,  1, 16'h0030, 0, 0);
        do_op(OP_DIV, 8'd24,  8'd2,  1, 16'h000C, 0, 0);
        do_op(OP_DIV, 8'd200, 8'd7,  1, 16'h041C, 0, 2);
        do_op(OP_MUL, 8'd255, 8'd255, 1, 16'hFE01, 0, 0);
        do_op(OP_DIV, 8'd5,   8'd9,  1, 16'h0500, 0, 0);
        do_op(OP_DIV, 8'd37,  8'd0,  1, 16'h25FF, 1, 0);
        do_op(OP_MUL, 8'd3,   8'd3,  1, 16'h0009, 0, 0);
        do_op(OP_MUL, 8'd10,  8'd10, 1, 16'h0064, 0, 5);
        do_op(OP_DIV, 8'd123, 8'd1,  1, 16'h007B, 0, 0);

        // Abort a divide with reset before its fourth iteration edge.
        @(negedge clk);
        wait_ready(ok);
        in_valid = 1'b1;
        op = OP_DIV;
        a = 8'd200;
        b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_state", state_dbg, IDLE);
        rst_n = 1'b1;
        do_op(OP_DIV, 8'd100, 8'd10, 1, 16'h000A, 0, 0);

        // Random operations; about one divide in eight uses a zero divisor.
        for (int i = 0; i < 60; i++) begin
            ro = 1'($urandom);
            rx = W'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            e  = ref_calc(ro, rx, ry);
            do_op(ro, rx, ry, 1, e[2*W-1:0], e[2*W], $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
